// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Bundle between the single-cycle core's data port and the
//               data-memory responder. It carries the core access
//               (CEN/WEN/OEN/A/Data2Mem -> ReadDataMem), the status outputs
//               (err_conflict, rd_cnt, wr_cnt) and the handshaked dump stream.
//               slave  : the memory responder.
//               master : the core / bench side.
// Revision    : 1.0  initial release
// ============================================================================
interface data_mem_responder_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // Core data port (all enables active low)
    logic              CEN;
    logic              WEN;
    logic              OEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] Data2Mem;
    logic [DATA_W-1:0] ReadDataMem;

    // Status
    logic              err_conflict;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    // Dump stream
    logic              dump_req;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    modport slave (
        input  CEN, WEN, OEN, A, Data2Mem, dump_req, dump_ready,
        output ReadDataMem, err_conflict, rd_cnt, wr_cnt,
               dump_valid, dump_addr, dump_data, dump_done
    );

    modport master (
        output CEN, WEN, OEN, A, Data2Mem, dump_req, dump_ready,
        input  ReadDataMem, err_conflict, rd_cnt, wr_cnt,
               dump_valid, dump_addr, dump_data, dump_done
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory slave for a single-cycle core. DEPTH words of
//               DATA_W bits with a combinational read (a load completes in
//               the core's cycle) and a synchronous write. Also provides a
//               sticky read/write conflict flag, saturating access counters
//               and a ready/valid dump port that streams every word out in
//               address order.
// Ports       : clk          - single clock, rising edge
//               rst_n        - synchronous active-low reset; clears memory,
//                              status, counters and the dump FSM
//               bus (slave)  - CEN/WEN/OEN/A/Data2Mem in, ReadDataMem out
//                              err_conflict, rd_cnt, wr_cnt out
//                              dump_req/dump_ready in,
//                              dump_valid/dump_addr/dump_data/dump_done out
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int CNT_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    data_mem_responder_if.slave    bus
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DUMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic w_rd_en;      // read port drives data (CEN=0, OEN=0)
    logic w_wr_en;      // write happens at this edge (CEN=0, WEN=0)
    logic w_rd_count;   // pure read: a conflict cycle counts as a write only
    logic w_conflict;   // write and output enable together

    assign w_rd_en    = ~bus.CEN & ~bus.OEN;
    assign w_wr_en    = ~bus.CEN & ~bus.WEN;
    assign w_rd_count = w_rd_en & bus.WEN;
    assign w_conflict = w_rd_en & ~bus.WEN;

    // ------------------------------------------------------------------
    // Storage: one resettable register per word. w_mem is the current
    // (pre-edge) contents, so every combinational reader sees the old word
    // during a write cycle and the new word from the next cycle onward.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_mem [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DATA_W-1:0] word_q;
        logic [DATA_W-1:0] word_d;

        always_comb begin
            word_d = word_q;
            if (w_wr_en && (bus.A == ADDR_W'(gi))) begin
                word_d = bus.Data2Mem;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                word_q <= '0;
            end else begin
                word_q <= word_d;
            end
        end

        assign w_mem[gi] = word_q;
    end

    assign bus.ReadDataMem = w_rd_en ? w_mem[bus.A] : '0;

    // ------------------------------------------------------------------
    // Sticky conflict flag and saturating access counters
    // ------------------------------------------------------------------
    logic             err_conflict_q, err_conflict_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        err_conflict_d = err_conflict_q | w_conflict;

        rd_cnt_d = rd_cnt_q;
        if (w_rd_count && (rd_cnt_q != c_cnt_max)) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end

        wr_cnt_d = wr_cnt_q;
        if (w_wr_en && (wr_cnt_q != c_cnt_max)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_conflict_q <= 1'b0;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
        end else begin
            err_conflict_q <= err_conflict_d;
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
        end
    end

    assign bus.err_conflict = err_conflict_q;
    assign bus.rd_cnt       = rd_cnt_q;
    assign bus.wr_cnt       = wr_cnt_q;

    // ------------------------------------------------------------------
    // Dump FSM: IDLE -> DUMP (one word per accepted handshake) -> DONE
    // (single-cycle done pulse) -> IDLE.
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dump_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            dump_addr_q <= dump_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.dump_req) begin
                    state_d     = S_DUMP;
                    dump_addr_d = '0;
                end
            end
            S_DUMP: begin
                // dump_valid is implied by the state, so ready alone accepts.
                if (bus.dump_ready) begin
                    if (dump_addr_q == c_last_addr) begin
                        state_d = S_DONE;
                    end else begin
                        dump_addr_d = dump_addr_q + ADDR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.dump_valid = (state_q == S_DUMP);
    assign bus.dump_done  = (state_q == S_DONE);
    assign bus.dump_addr  = dump_addr_q;
    // Live contents: a core write to the presented address shows up here
    // only after its edge, so the accepted word is always the pre-edge value.
    assign bus.dump_data  = (state_q == S_DUMP) ? w_mem[dump_addr_q] : '0;

endmodule
`default_nettype wire
